ship_heading_ctrl: RTL and testbench

- Upstream stage of the ship sprite renderer. Converts rotate-left/rotate-right button input into the 6-bit direction code that drives the ship sprite select.
- Maintains a 32-step heading ring, clockwise from up. Gives one immediate step on press, then auto-repeats at a frame-tick-based rate while the button is held.
- Commits a new heading only while the sprite drawer is idle, so a sprite is never drawn with mixed orientations.

---
 rtl/ship_heading_ctrl_if.sv | 26 ++
 rtl/ship_heading_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ship_heading_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ship_heading_ctrl_if.sv
// ship_heading_ctrl_if
// Groups the frame/button/drawer inputs and the heading/sprite-select outputs
// of the ship heading controller.
//   master : drives frame_tick, rot_left, rot_right, draw_busy;
//            observes direction, heading, redraw, pending
//   slave  : the controller side (mirror of master)
interface ship_heading_ctrl_if;
    logic       frame_tick;
    logic       rot_left;
    logic       rot_right;
    logic       draw_busy;
    logic [5:0] direction;
    logic [4:0] heading;
    logic       redraw;
    logic       pending;

    modport master (
        output frame_tick, rot_left, rot_right, draw_busy,
        input  direction, heading, redraw, pending
    );

    modport slave (
        input  frame_tick, rot_left, rot_right, draw_busy,
        output direction, heading, redraw, pending
    );
endinterface

// File: rtl/ship_heading_ctrl.sv
// ship_heading_ctrl
// Turns rotate-left/right button levels into a 32-step heading (clockwise
// from up) and the 6-bit sprite-select direction code. A press gives one
// immediate step, holding auto-repeats every REPEAT_TICKS frame ticks.
// Steps are committed only while the sprite drawer is idle.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   bus.slave:
//     frame_tick in  one-cycle pulse per frame
//     rot_left   in  rotate-left button level
//     rot_right  in  rotate-right button level
//     draw_busy  in  sprite drawer mid-sprite
//     direction  out {x_neg, x_mag[1:0], y_up, y_mag[1:0]}
//     heading    out heading index 0..31
//     redraw     out one-cycle pulse, first cycle the new direction is valid
//     pending    out a step is waiting for draw_busy to drop
//
// Optional build macro: BUTTON_SYNC_EN -- adds a 2-flop synchronizer on each
// button input (adds 2 cycles of input-to-commit latency).
module ship_heading_ctrl #(
    parameter int REPEAT_TICKS = 8,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    ship_heading_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_left;
    logic w_right;

`ifdef BUTTON_SYNC_EN
    logic [1:0] r_left_sync;
    logic [1:0] r_right_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_left_sync  <= 2'b00;
            r_right_sync <= 2'b00;
        end else begin
            r_left_sync  <= {r_left_sync[0],  bus.rot_left};
            r_right_sync <= {r_right_sync[0], bus.rot_right};
        end
    end

    assign w_left  = r_left_sync[1];
    assign w_right = r_right_sync[1];
`else
    assign w_left  = bus.rot_left;
    assign w_right = bus.rot_right;
`endif

    // Both or neither pressed resolves to no request.
    logic w_want_l;
    logic w_want_r;
    assign w_want_l = w_left & ~w_right;
    assign w_want_r = w_right & ~w_left;

    // ------------------------------------------------------------------
    // Press / auto-repeat FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_act_right;    // button that owns the current hold
    logic             w_act_right_nxt;
    logic             w_req;          // step request this cycle
    logic             w_req_right;    // its sign: 1 = clockwise

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_act_right <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_act_right <= w_act_right_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_act_right_nxt = r_act_right;
        w_req           = 1'b0;
        w_req_right     = r_act_right;
        case (r_state)
            S_IDLE: begin
                if (w_want_l || w_want_r) begin
                    w_req           = 1'b1;
                    w_req_right     = w_want_r;
                    w_act_right_nxt = w_want_r;
                    w_state_nxt     = S_HOLD;
                    w_cnt_nxt       = '0;
                end
            end
            S_HOLD: begin
                // Hold persists only while the owning button is the sole one.
                if (r_act_right ? w_want_r : w_want_l) begin
                    if (bus.frame_tick) begin
                        if (r_cnt == LP_LAST) begin
                            w_req     = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending step and commit
    // ------------------------------------------------------------------
    logic       r_pending;
    logic       r_sign_right;
    logic       w_pending_nxt;
    logic       w_sign_right_nxt;
    logic       w_commit;
    logic       w_pend_live;
    logic [4:0] r_heading;
    logic [5:0] r_direction;
    logic       r_redraw;
    logic [4:0] w_head_step;

    assign w_commit    = r_pending & ~bus.draw_busy;
    // A committing step is consumed at this edge, so a request arriving on
    // the same edge starts a fresh pending step rather than being dropped.
    assign w_pend_live = r_pending & ~w_commit;
    assign w_head_step = r_sign_right ? (r_heading + 5'd1) : (r_heading - 5'd1);

    always_comb begin
        w_pending_nxt    = w_pend_live;
        w_sign_right_nxt = r_sign_right;
        if (w_req) begin
            if (!w_pend_live) begin
                w_pending_nxt    = 1'b1;
                w_sign_right_nxt = w_req_right;
            end else if (r_sign_right != w_req_right) begin
                // Opposite steps cancel; same-sign duplicates are dropped.
                w_pending_nxt = 1'b0;
            end
        end
    end

    // Sprite-select code for a heading. Odd quadrants use the mirrored
    // magnitude table; x_neg on the left half, y_up on the top half.
    function automatic logic [5:0] f_dir(input logic [4:0] h);
        logic [3:0] mag;  // {x_mag, y_mag}
        logic [1:0] q;
        q = h[4:3];
        if (!q[0]) begin
            case (h[2:0])
                3'd0:    mag = {2'd0, 2'd3};
                3'd1:    mag = {2'd1, 2'd3};
                3'd2:    mag = {2'd1, 2'd2};
                3'd3:    mag = {2'd2, 2'd3};
                3'd4:    mag = {2'd1, 2'd1};
                3'd5:    mag = {2'd3, 2'd2};
                3'd6:    mag = {2'd2, 2'd1};
                default: mag = {2'd3, 2'd1};
            endcase
        end else begin
            case (h[2:0])
                3'd0:    mag = {2'd3, 2'd0};
                3'd1:    mag = {2'd3, 2'd1};
                3'd2:    mag = {2'd2, 2'd1};
                3'd3:    mag = {2'd3, 2'd2};
                3'd4:    mag = {2'd1, 2'd1};
                3'd5:    mag = {2'd2, 2'd3};
                3'd6:    mag = {2'd1, 2'd2};
                default: mag = {2'd1, 2'd3};
            endcase
        end
        return {q[1], mag[3:2], ~(q[1] ^ q[0]), mag[1:0]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending    <= 1'b0;
            r_sign_right <= 1'b0;
            r_heading    <= 5'd0;
            r_direction  <= 6'b000111;
            r_redraw     <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_sign_right <= w_sign_right_nxt;
            r_redraw     <= w_commit;
            if (w_commit) begin
                r_heading   <= w_head_step;
                r_direction <= f_dir(w_head_step);
            end
        end
    end

    assign bus.heading   = r_heading;
    assign bus.direction = r_direction;
    assign bus.redraw    = r_redraw;
    assign bus.pending   = r_pending;

endmodule

// File: tb/tb_ship_heading_ctrl.sv
// Directed bench for ship_heading_ctrl (REPEAT_TICKS=4). Each step that is
// expected to commit pushes {heading, direction} onto a scoreboard; every
// redraw pulse pops and compares it.
module tb_ship_heading_ctrl;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    logic prev_rd;
    logic [4:0]  mh;          // model heading
    logic [10:0] sb[$];

    ship_heading_ctrl_if bus();

    ship_heading_ctrl #(.REPEAT_TICKS(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] exp_dir(input logic [4:0] h);
        logic [3:0] m;
        logic       xn;
        logic       yu;
        case (h[4:3])
            2'd0: begin xn = 1'b0; yu = 1'b1; end
            2'd1: begin xn = 1'b0; yu = 1'b0; end
            2'd2: begin xn = 1'b1; yu = 1'b0; end
            default: begin xn = 1'b1; yu = 1'b1; end
        endcase
        if (h[3] == 1'b0)
            case (h[2:0])
                3'd0: m = 4'h3; 3'd1: m = 4'h7; 3'd2: m = 4'h6; 3'd3: m = 4'hB;
                3'd4: m = 4'h5; 3'd5: m = 4'hE; 3'd6: m = 4'h9; default: m = 4'hD;
            endcase
        else
            case (h[2:0])
                3'd0: m = 4'hC; 3'd1: m = 4'hD; 3'd2: m = 4'h9; 3'd3: m = 4'hE;
                3'd4: m = 4'h5; 3'd5: m = 4'hB; 3'd6: m = 4'h6; default: m = 4'h7;
            endcase
        return {xn, m[3:2], yu, m[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_step(input logic right);
        mh = right ? mh + 5'd1 : mh - 5'd1;
        sb.push_back({mh, exp_dir(mh)});
    endtask

    task automatic hold(input logic l, input logic r, input int n);
        bus.rot_left  = l;
        bus.rot_right = r;
        repeat (n) @(posedge clk);
        #1;
        bus.rot_left  = 1'b0;
        bus.rot_right = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every redraw must match the oldest expected step.
    always @(negedge clk) begin
        if (bus.redraw === 1'b1) begin
            chk("redraw_single", 32'(prev_rd), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL redraw_unexpected observed heading=%0d expected no redraw", bus.heading);
            end else begin
                chk("commit", 32'({bus.heading, bus.direction}), 32'(sb.pop_front()));
            end
        end
        prev_rd <= bus.redraw;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        prev_rd = 1'b0;
        mh = 5'd0;
        reset_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.rot_left   = 1'b0;
        bus.rot_right  = 1'b0;
        bus.draw_busy  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_heading", 32'(bus.heading), 32'd0);
        chk("rst_direction", 32'(bus.direction), 32'b000111);
        chk("rst_redraw", 32'(bus.redraw), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);

        // Right held 3 cycles, no ticks: a single step
        expect_step(1'b1);
        hold(1'b0, 1'b1, 3);
        idle(5);
        @(negedge clk);
        chk("hold3_heading", 32'(bus.heading), 32'd1);
        chk("hold3_direction", 32'(bus.direction), 32'b001111);

        // Left taps: 1 -> 0 -> 31 (wrap)
        repeat (2) begin
            expect_step(1'b0);
            hold(1'b1, 1'b0, 1);
            idle(5);
        end
        @(negedge clk);
        chk("wrap_heading", 32'(bus.heading), 32'd31);
        chk("wrap_direction", 32'(bus.direction), 32'b101111);

        // Nine right taps: 31 -> 8
        repeat (9) begin
            expect_step(1'b1);
            hold(1'b0, 1'b1, 1);
            idle(5);
        end
        @(negedge clk);
        chk("right9_heading", 32'(bus.heading), 32'd8);
        chk("right9_direction", 32'(bus.direction), 32'b011000);

        // Stall behind draw_busy
        bus.draw_busy = 1'b1;
        expect_step(1'b1);
        hold(1'b0, 1'b1, 1);
        idle(20);
        @(negedge clk);
        chk("stall_pending", 32'(bus.pending), 32'd1);
        chk("stall_heading", 32'(bus.heading), 32'd8);
        @(posedge clk);
        #1 bus.draw_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_redraw", 32'(bus.redraw), 32'd1);
        chk("release_pending", 32'(bus.pending), 32'd0);
        chk("release_heading", 32'(bus.heading), 32'd9);
        idle(3);

        // Both buttons together: no request
        hold(1'b1, 1'b1, 5);
        idle(4);
        @(negedge clk);
        chk("both_pending", 32'(bus.pending), 32'd0);
        chk("both_heading", 32'(bus.heading), 32'd9);

        // Reset while a step is pending behind busy
        bus.draw_busy = 1'b1;
        hold(1'b0, 1'b1, 1);
        idle(4);
        @(negedge clk);
        chk("prerst_pending", 32'(bus.pending), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_heading", 32'(bus.heading), 32'd0);
        chk("midrst_pending", 32'(bus.pending), 32'd0);
        chk("midrst_redraw", 32'(bus.redraw), 32'd0);
        chk("midrst_direction", 32'(bus.direction), 32'b000111);
        mh = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.draw_busy = 1'b0;
        idle(6);
        @(negedge clk);
        chk("postrst_heading", 32'(bus.heading), 32'd0);

        // Auto-repeat: tick every 2nd cycle while right is held
        repeat (6) expect_step(1'b1);
        @(posedge clk);
        #1 bus.rot_right = 1'b1;
        for (int i = 0; i < 42; i++) begin
            bus.frame_tick = (i % 2) == 1;
            @(posedge clk);
            #1;
        end
        bus.rot_right  = 1'b0;
        bus.frame_tick = 1'b0;
        idle(6);
        @(negedge clk);
        chk("repeat_heading", 32'(bus.heading), 32'd6);
        chk("repeat_direction", 32'(bus.direction), 32'(exp_dir(5'd6)));
        chk("repeat_pending", 32'(bus.pending), 32'd0);

        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
